writeback_regfile: RTL
======================

// Module: writeback_regfile
// PURPOSE
// - Consumer (W-stage) end of the MEM/WB pipeline interface: selects the writeback result and commits it to the architectural register file.
// - Holds the 32x32 RISC-V integer register file, with x0 hardwired to zero.
// - Serves the two decode-stage read ports with same-cycle write-through bypass.
// - Exports result_W for E-stage forwarding and a retired-write counter for debug/perf.
// PARAMETERS
// - XLEN      32  datapath width
// - NREGS     32  architectural registers (index width = $clog2(NREGS) = 5)
// - CNT_W     32  width of retired-write counter
// PORTS
// - clk                      in   1      single clock, rising edge
// - rst                      in   1      synchronous reset, active-high
// - ALU_result_W             in   XLEN   ALU result from MEM/WB register
// - data_memory_RD_W         in   XLEN   load data from MEM/WB register
// - register_file_WA_W       in   5      destination register index
// - ctrl_register_file_WE_W  in   1      write enable
// - ctrl_result_W            in   1      0 = ALU result, 1 = memory data
// - register_file_RA1_D      in   5      decode read address 1 (rs1)
// - register_file_RA2_D      in   5      decode read address 2 (rs2)
// - register_file_RD1_D      out  XLEN   read data 1 (combinational)
// - register_file_RD2_D      out  XLEN   read data 2 (combinational)
// - result_W                 out  XLEN   selected writeback value (combinational)
// - retired_writes           out  CNT_W  count of committed non-x0 writes
// BEHAVIOUR
// - result_W = ctrl_result_W ? data_memory_RD_W : ALU_result_W. Pure mux, 0-cycle latency.
// - Commit condition: commit = WE_W & (WA_W != 0) & ~rst. On the rising edge with commit true, regs[WA_W] <= result_W.
// - x0: never written. Reads of index 0 always return 0, including when bypass would match.
// - Read ports are combinational.
//   - RDn = 0 if RAn == 0.
//   - Otherwise RDn = result_W if commit && WA_W == RAn (write-through bypass; no extra pipeline stall needed for W->D).
//   - Otherwise RDn = regs[RAn].
// - Both read ports may address the same register, and/or the register being written, in the same cycle. Both return identical values.
// - Reset, synchronous: on a rising edge with rst=1, regs[1..31] <= 0 and retired_writes <= 0. Any write presented that cycle is dropped, not committed.
// - During rst=1, read ports return stored contents (bypass disabled, since commit=0). From the first edge after reset, every read returns 0.
// - Reset mid-stream: an instruction in W while rst=1 is lost. The pipeline owner flushes upstream stages on the same reset.
// - retired_writes increments by 1 on every edge with commit=1. Wraps modulo 2^CNT_W (0xFFFF_FFFF -> 0). No saturation.
// - A write with WE_W=1 and WA_W=0 is a no-op: regs unchanged, counter unchanged.
// - Inputs are sampled only at the clock edge. X on WA_W while WE_W=0 must not corrupt state.
// STRUCTURE
// - Shared package (riscv_pkg): XLEN, NREGS, REG_IDX_W=5, RESULT_SRC_ALU=1'b0, RESULT_SRC_MEM=1'b1.
// - One sub-module: regfile_read_port (address, stored data, commit, WA_W, result_W -> data), instantiated twice.
// - Storage is a flat reg array [1:NREGS-1]. No entry 0 is stored.
// TESTING
// - Reset: drive rst=1 for 1 cycle, then read x1..x31 -> all 0; retired_writes=0.
// - Basic write/read: WE=1, WA=5, ctrl_result=0, ALU=0xDEADBEEF; next cycle RA1=5 -> RD1=0xDEADBEEF; counter=1.
// - Result select: WE=1, WA=7, ctrl_result=1, MEM=0x0000_1234, ALU=0xFFFF_FFFF -> regs[7]=0x1234; result_W=0x1234 during that cycle.
// - Bypass: same cycle WE=1, WA=9, ALU=0xA5A5A5A5, RA1=RA2=9 -> RD1=RD2=0xA5A5A5A5 before the edge. With WE=0 -> old value.
// - x0: WE=1, WA=0, ALU=0x1; RA1=0 -> RD1=0 both that cycle and the next; counter unchanged.
// - Reset overrides write: rst=1 with WE=1, WA=3, ALU=0x55 -> after the edge regs[3]=0, counter=0. Separately, preload the counter to 0xFFFF_FFFF via force, then 1 write -> counter=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V integer datapath constants used by the writeback/register-file slice.
package riscv_pkg;
    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = $clog2(NREGS);

    localparam logic RESULT_SRC_ALU = 1'b0;
    localparam logic RESULT_SRC_MEM = 1'b1;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port with x0 masking and W->D write-through bypass.
module regfile_read_port
    import riscv_pkg::*;
(
    input  logic [REG_IDX_W-1:0] addr,
    input  logic [XLEN-1:0]      stored,
    input  logic                 commit,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [XLEN-1:0]      result,
    output logic [XLEN-1:0]      data
);

    always_comb begin
        data = stored;
        // x0 wins over the bypass so a write aimed at x0 can never leak through
        if (addr == '0)
            data = '0;
        else if (commit && (wa == addr))
            data = result;
    end

endmodule

// File: rtl/writeback_regfile.sv
// W-stage result select, 31-entry architectural register file and retired-write counter.
module writeback_regfile
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      ALU_result_W,
    input  logic [XLEN-1:0]      data_memory_RD_W,
    input  logic [REG_IDX_W-1:0] register_file_WA_W,
    input  logic                 ctrl_register_file_WE_W,
    input  logic                 ctrl_result_W,
    input  logic [REG_IDX_W-1:0] register_file_RA1_D,
    input  logic [REG_IDX_W-1:0] register_file_RA2_D,
    output logic [XLEN-1:0]      register_file_RD1_D,
    output logic [XLEN-1:0]      register_file_RD2_D,
    output logic [XLEN-1:0]      result_W,
    output logic [CNT_W-1:0]     retired_writes
);

    logic [XLEN-1:0]  regs [1:NREGS-1];
    logic [CNT_W-1:0] cnt_q;
    logic             commit;
    logic [XLEN-1:0]  stored1;
    logic [XLEN-1:0]  stored2;

    assign result_W = (ctrl_result_W == RESULT_SRC_MEM) ? data_memory_RD_W : ALU_result_W;

    // Logical AND keeps an unknown WA_W harmless whenever WE_W is low
    assign commit = ctrl_register_file_WE_W && (register_file_WA_W != '0) && !rst;

    assign stored1 = (register_file_RA1_D == '0) ? '0 : regs[register_file_RA1_D];
    assign stored2 = (register_file_RA2_D == '0) ? '0 : regs[register_file_RA2_D];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++)
                regs[i] <= '0;
            cnt_q <= '0;
        end else if (commit) begin
            regs[register_file_WA_W] <= result_W;
            cnt_q                    <= cnt_q + 1'b1;
        end
    end

    assign retired_writes = cnt_q;

    regfile_read_port u_rd1 (
        .addr   (register_file_RA1_D),
        .stored (stored1),
        .commit (commit),
        .wa     (register_file_WA_W),
        .result (result_W),
        .data   (register_file_RD1_D)
    );

    regfile_read_port u_rd2 (
        .addr   (register_file_RA2_D),
        .stored (stored2),
        .commit (commit),
        .wa     (register_file_WA_W),
        .result (result_W),
        .data   (register_file_RD2_D)
    );

endmodule
